// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to let divide-by-zero, signed overflow and zero-operand multiplies bypass the loop.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  b_mag;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic              neg_a;
  logic              neg_b;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   result;

  function automatic logic signed_a(input logic [2:0] f);
    return f[2] ? ~f[0] : (f[1:0] != 2'b11);
  endfunction

  function automatic logic signed_b(input logic [2:0] f);
    return f[2] ? ~f[0] : ~f[1];
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic is_special(input logic [2:0] f, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    if (f[2])
      return (b == '0) || (!f[0] && (a == MOST_NEG) && (b == '1));
    else
      return (a == '0) || (b == '0);
  endfunction

  // RISC-V defined results for divide-by-zero and signed overflow; zero-operand multiplies give 0.
  function automatic logic [XLEN-1:0] special_val(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    if (!f[2])
      return '0;
    else if (b == '0)
      return f[1] ? a : '1;
    else
      return f[1] ? '0 : a;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_nxt = is_special(op, in1, in2) ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt == LAST_CNT)
          state_nxt = DONE;
      end
      DONE: begin
        if (out_valid && out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
    div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, b_mag};
    neg_a     = signed_a(op_q) & a_q[XLEN-1];
    neg_b     = signed_b(op_q) & b_q[XLEN-1];
    prod      = {acc_hi, acc_lo};
    prod_s    = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
    result    = '0;
    if (is_special(op_q, a_q, b_q))
      result = special_val(op_q, a_q, b_q);
    else if (!op_q[2])
      result = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (op_q[1])
      result = neg_a ? (~acc_hi + 1'b1) : acc_hi;
    else
      result = (neg_a ^ neg_b) ? (~acc_lo + 1'b1) : acc_lo;
  end

  // Loop runs on magnitudes; signs are reapplied when cnt reaches XLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      md_out    <= '0;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      b_mag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            a_q    <= in1;
            b_q    <= in2;
            acc_hi <= '0;
            acc_lo <= mag(in1, signed_a(op));
            b_mag  <= mag(in2, signed_b(op));
            cnt    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            if (is_special(op, in1, in2))
              md_out <= special_val(op, in1, in2);
`endif
          end
        end
        CALC: begin
          if (cnt == LAST_CNT) begin
            md_out    <= result;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (op_q[2]) begin
              if (!div_trial[XLEN]) begin
                acc_hi <= div_trial[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
              end else begin
                acc_hi <= {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
              end
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
            end
          end
        end
        DONE: begin
          // An early-out entry arrives with out_valid low and raises it one cycle later.
          if (!out_valid)
            out_valid <= 1'b1;
          else if (out_ready)
            out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] md_out;

  int checks   = 0;
  int failures = 0;

  localparam int CALC_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .md_out    (md_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    op       = f;
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; the unit must ignore them.
    in_valid = 1'b0;
    op       = F_DIVU;
    in1      = 32'hDEADBEEF;
    in2      = 32'h0;
  endtask

  task automatic wait_result(input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_val"}, {32'd0, md_out}, {32'd0, exp});
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_hs_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    start_op(f, a, b, tag);
    wait_result(exp, lat, tag);
    handshake(tag);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'b000;
    in1       = 32'h0;
    in2       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_md_out", {32'd0, md_out}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op(F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, CALC_LAT, "mul_neg");
    run_op(F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, CALC_LAT, "mulh_minmin");
    run_op(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, CALC_LAT, "mulhu_ones");
    run_op(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, CALC_LAT, "mulhsu_ones");
    run_op(F_MUL,    32'd0,        32'd5,        32'd0,        SPECIAL_LAT, "mul_zero");

    run_op(F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, CALC_LAT, "div_neg7_2");
    run_op(F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, CALC_LAT, "rem_neg7_2");
    run_op(F_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, CALC_LAT, "div_7_neg2");
    run_op(F_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        CALC_LAT, "rem_7_neg2");
    run_op(F_DIVU,   32'd100,      32'd7,        32'd14,       CALC_LAT, "divu_100_7");
    run_op(F_REMU,   32'd100,      32'd7,        32'd2,        CALC_LAT, "remu_100_7");

    run_op(F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPECIAL_LAT, "divu_by0");
    run_op(F_REM,    32'd5,        32'd0,        32'd5,        SPECIAL_LAT, "rem_by0");
    run_op(F_DIV,    32'hFFFFFFFA, 32'd0,        32'hFFFFFFFF, SPECIAL_LAT, "div_neg_by0");
    run_op(F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT, "div_ovf");
    run_op(F_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPECIAL_LAT, "rem_ovf");

    start_op(F_MUL, 32'd6, 32'd7, "bp");
    wait_result(32'd42, CALC_LAT, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op       = F_DIV;
      in1      = $urandom;
      in2      = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_md_out", {32'd0, md_out}, 64'd42);
    end
    handshake("bp");
    run_op(F_DIVU, 32'd100, 32'd7, 32'd14, CALC_LAT, "after_bp");

    start_op(F_MUL, 32'd3, 32'd5, "abort");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_md_out", {32'd0, md_out}, 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_op(F_DIVU, 32'd9, 32'd3, 32'd3, CALC_LAT, "divu_9_3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
